// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of CPU stores drained to a single-port data memory when loads leave the port idle
// Ports: clk/rst (sync, active high); cpu_we/cpu_re/cpu_byte_op/cpu_addr/cpu_wdata request in, cpu_rdata/cpu_stall out;
// mem_we/mem_byte_op/mem_addr/mem_wdata drive the memory, mem_rdata is its combinational read data;
// sb_count/sb_empty report occupancy. Define STORE_BUFFER_FWD_EN to forward word-store data to matching word loads.
module store_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_we,
  input  logic                     cpu_re,
  input  logic                     cpu_byte_op,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_we,
  output logic                     mem_byte_op,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] byte_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic full, empty, load, match, fwd, hz_stall, st_stall, drain, push;
`ifdef STORE_BUFFER_FWD_EN
  logic young_byte;
  logic [DATA_WIDTH-1:0] young_data;
`endif
  // scan from head to tail so the last hit is the youngest matching store
  always_comb begin
    match = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    young_byte = 1'b0;
    young_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && addr_q[head_q + PW'(i)][ADDRESS_WIDTH-1:2] == cpu_addr[ADDRESS_WIDTH-1:2]) begin
        match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        young_byte = byte_q[head_q + PW'(i)];
        young_data = data_q[head_q + PW'(i)];
`endif
      end
    end
  end
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  // a simultaneous store+load is a store: it never hazard-stalls, but cpu_re still claims the port
  assign load = cpu_re & ~cpu_we;
`ifdef STORE_BUFFER_FWD_EN
  assign fwd = load & match & ~cpu_byte_op & ~young_byte;
  assign cpu_rdata = fwd ? young_data : mem_rdata;
`else
  assign fwd = 1'b0;
  assign cpu_rdata = mem_rdata;
`endif
  assign hz_stall = load & match & ~fwd;
  assign st_stall = cpu_we & full;
  // a full buffer always drains so a blocked store cannot deadlock behind a held load
  assign drain = ~rst & ~empty & (~cpu_re | hz_stall | fwd | st_stall);
  assign push = ~rst & cpu_we & ~full;
  assign cpu_stall = ~rst & (hz_stall | st_stall);
  assign mem_we = drain;
  assign mem_addr = drain ? addr_q[head_q] : cpu_addr;
  assign mem_wdata = drain ? data_q[head_q] : cpu_wdata;
  assign mem_byte_op = drain ? byte_q[head_q] : cpu_byte_op;
  assign head_d = head_q + PW'(drain);
  assign tail_d = tail_q + PW'(push);
  assign count_d = count_q + CW'(push) - CW'(drain);
  assign sb_count = count_q;
  assign sb_empty = empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // payload needs no reset: occupancy alone decides which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
      byte_q[tail_q] <= cpu_byte_op;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer with a big-endian word memory model
module tb_store_buffer;
  logic clk = 0, rst = 1, cpu_we = 0, cpu_re = 0, cpu_byte_op = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, mem_we, mem_byte_op, sb_empty;
  logic [2:0] sb_count;
  logic [31:0] mem [0:65535];
  logic [64:0] wq [$];
  logic [31:0] rq [$];
  int errors = 0, checks = 0, peak = 0, st = 0, tot = 0;
`ifdef STORE_BUFFER_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  store_buffer dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_byte_op(cpu_byte_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_we(mem_we), .mem_byte_op(mem_byte_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sb_count(sb_count), .sb_empty(sb_empty)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[17:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_byte_op) mem[mem_addr[17:2]][(3 - int'(mem_addr[1:0])) * 8 +: 8] <= mem_wdata[7:0];
      else mem[mem_addr[17:2]] <= mem_wdata;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    logic [64:0] e;
    if (sb_count > peak) peak = sb_count;
    if (!rst && mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: addr %h data %h", mem_addr, mem_wdata);
      end else begin
        e = wq.pop_front();
        chk("wr addr", mem_addr, e[63:32]);
        chk("wr data", mem_wdata, e[31:0]);
        chk("wr byte_op", {31'd0, mem_byte_op}, {31'd0, e[64]});
      end
    end
    if (!rst && cpu_re && !cpu_we && !cpu_stall) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected load completion: data %h", cpu_rdata);
      end else chk("rd data", cpu_rdata, rq.pop_front());
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_go(output int n);
    n = 0;
    @(negedge clk);
    while (cpu_stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL stall timeout: still stalled after %0d cycles, required release", n);
    end
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic hold_re, input logic expw, output int n);
    cpu_we = 1; cpu_re = hold_re; cpu_addr = a; cpu_wdata = d; cpu_byte_op = b;
    if (expw) wq.push_back({b, a, d});
    wait_go(n);
    cyc();
    cpu_we = 0; cpu_re = 0;
  endtask
  task automatic load(input string nm, input logic [31:0] a, input logic b, input logic [31:0] exp, input int exp_st);
    int n;
    cpu_re = 1; cpu_we = 0; cpu_addr = a; cpu_byte_op = b;
    rq.push_back(exp);
    wait_go(n);
    chk(nm, n, exp_st);
    cyc();
    cpu_re = 0;
  endtask
  task automatic drain_all(input string nm);
    for (int k = 0; k < 50 && !sb_empty; k++) cyc();
    chk(nm, {31'd0, sb_empty}, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 0;
    cpu_we = 1;
    cpu_addr = 32'h10000;
    @(negedge clk);
    chk("reset mem_we", {31'd0, mem_we}, 0);
    chk("reset stall", {31'd0, cpu_stall}, 0);
    cyc();
    rst = 0; cpu_we = 0;
    @(negedge clk);
    chk("post-reset count", {29'd0, sb_count}, 0);
    chk("post-reset empty", {31'd0, sb_empty}, 1);
    cyc();
    peak = 0; tot = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'h10000 + 32'(i * 4), 32'h11111111 * (i + 1), 0, 0, 1, st);
      tot += st;
    end
    chk("t1 store stalls", tot, 0);
    drain_all("t1 drained");
    chk("t1 peak count", peak, 1);
    for (int i = 0; i < 4; i++) chk("t1 memory word", mem[16'h4000 + 16'(i)], 32'h11111111 * (i + 1));
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'h10100 + 32'(i * 4), 32'hA0 + 32'(i), 0, 1, 1, st);
      tot += st;
    end
    chk("t2 fill stalls", tot, 0);
    chk("t2 full count", {29'd0, sb_count}, 4);
    store(32'h10110, 32'hA4, 0, 0, 1, st);
    chk("t2 fifth store stalls", st, 1);
    drain_all("t2 drained");
    store(32'h10010, 32'hDEADBEEF, 0, 0, 1, st);
    load("t3 word load stalls", 32'h10010, 0, 32'hDEADBEEF, FWD ? 0 : 1);
    drain_all("t3 drained");
    store(32'h10013, 32'hAB, 1, 0, 1, st);
    load("t4 byte-hazard stalls", 32'h10010, 0, 32'hDEADBEAB, 1);
    drain_all("t4 drained");
    store(32'h10020, 32'h1, 0, 0, 1, st);
    store(32'h10020, 32'h2, 0, 0, 1, st);
    load("t5 same-addr stalls", 32'h10020, 0, 32'h2, FWD ? 0 : 1);
    drain_all("t5 drained");
    store(32'h10050, 32'hA1, 0, 1, 1, st);
    store(32'h10054, 32'hB2, 0, 1, 1, st);
    store(32'h10050, 32'hC3, 0, 1, 1, st);
    load("t5b youngest-match stalls", 32'h10050, 0, 32'hC3, FWD ? 0 : 3);
    drain_all("t5b drained");
    store(32'h10030, 32'h55, 0, 0, 1, st);
    load("no-match load stalls", 32'h10004, 0, 32'h22222222, 0);
    drain_all("no-match drained");
    store(32'h10060, 32'h12345678, 0, 0, 1, st);
    load("byte load on word store stalls", 32'h10060, 1, 32'h12345678, 1);
    drain_all("byte load drained");
    for (int i = 0; i < 3; i++) store(32'h10040 + 32'(i * 4), 32'hF0 + 32'(i), 0, 1, 0, st);
    chk("t6 pending count", {29'd0, sb_count}, 3);
    rst = 1;
    @(negedge clk);
    chk("t6 reset mem_we", {31'd0, mem_we}, 0);
    chk("t6 reset stall", {31'd0, cpu_stall}, 0);
    cyc();
    rst = 0;
    chk("t6 count after reset", {29'd0, sb_count}, 0);
    chk("t6 empty after reset", {31'd0, sb_empty}, 1);
    for (int i = 0; i < 6; i++) cyc();
    chk("t6 discarded store absent", mem[16'h4010], 0);
    chk("write queue drained", wq.size(), 0);
    chk("read queue drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
